// File: rtl/irq_pkg.sv
// Shared definitions for the irq_ctrl interrupt controller.
//
// Contents:
//   N_IRQ_DEFAULT  - default number of interrupt lines
//   IRQ_MAX        - widest line count the arbiter helper supports
//   irq_state_t    - FSM state encoding (IDLE / REQ / SERVICE)
//   find_first_set - index of the lowest set bit, used by the arbiter
package irq_pkg;

  localparam int N_IRQ_DEFAULT = 4;
  localparam int IRQ_MAX       = 16;
  localparam int FFS_W         = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    SERVICE = 2'b10
  } irq_state_t;

  // Lowest set bit wins. An all-zero vector returns 0, so callers must
  // qualify the result with a separate "anything set" test.
  function automatic logic [FFS_W-1:0] find_first_set(input logic [IRQ_MAX-1:0] vec);
    logic [FFS_W-1:0] idx;
    idx = '0;
    for (int i = IRQ_MAX - 1; i >= 0; i--) begin
      if (vec[i]) idx = FFS_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-line input conditioning for irq_ctrl.
//
// A raw asynchronous line passes through a 2-flop synchroniser followed by
// a delay flop; rise pulses for exactly one clock when the synchronised
// level goes from 0 to 1, so a level held high yields a single pulse.
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   din  - raw asynchronous interrupt line
//   rise - one-cycle pulse on a synchronised rising edge
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic s1;
  logic s2;
  logic s2_d;

  // s1/s2 form the metastability synchroniser; s2_d remembers the
  // previous synchronised level so the edge can be detected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_d <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s2_d <= s2;
    end
  end

  assign rise = s2 & ~s2_d;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller for the Hunter_RV32 core.
//
// Each external line is synchronised and rising-edge detected; edges are
// latched as pending (even when masked), the enable mask selects which
// pending lines are eligible, and an arbiter picks one to present to the
// CPU through a req/ack handshake. After ack the interrupt stays in
// service until the CPU pulses irq_eoi. There is no nesting.
//
// Build option:
//   IRQ_PRIO_ROTATE_EN - round-robin arbitration starting after the last
//                        acknowledged line; when undefined, fixed priority
//                        with the lowest index winning.
//
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   irq_in      - raw asynchronous interrupt lines
//   mask_we     - mask write strobe, mask_wdata is the new enable mask
//   irq_ack     - CPU accepts the presented interrupt
//   irq_eoi     - CPU handler finished (one-cycle pulse)
//   irq_req     - registered interrupt request to the CPU
//   irq_id      - id of the requested or in-service interrupt
//   in_service  - a handler is active
//   mask        - current enable mask
//   pending     - current pending bits
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int N_IRQ = N_IRQ_DEFAULT,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  input  logic             irq_ack,
  input  logic             irq_eoi,
  output logic             irq_req,
  output logic [ID_W-1:0]  irq_id,
  output logic             in_service,
  output logic [N_IRQ-1:0] mask,
  output logic [N_IRQ-1:0] pending
);

  irq_state_t          state;
  irq_state_t          state_nxt;
  logic [ID_W-1:0]     id_nxt;
  logic [N_IRQ-1:0]    rise;
  logic [N_IRQ-1:0]    eligible;
  logic [N_IRQ-1:0]    ack_clr;
  logic [ID_W-1:0]     winner;
  logic [IRQ_MAX-1:0]  search;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_line
    irq_sync_edge u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (irq_in[g]),
      .rise (rise[g])
    );
  end

  assign eligible = pending & mask;

`ifdef IRQ_PRIO_ROTATE_EN
  logic [ID_W-1:0] last_served;
  int              start;
  int              pick;

  // Remember the most recently acknowledged line so the next search begins
  // just after it. Resetting to the top index makes line 0 first in line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_served <= ID_W'(N_IRQ - 1);
    end else if (state == REQ && irq_ack) begin
      last_served <= irq_id;
    end
  end

  // Rotate the eligible vector so the search start sits at bit 0, find the
  // first set bit, then rotate the result back into a real line index.
  always_comb begin
    start = int'(last_served) + 1;
    if (start >= N_IRQ) start = 0;
    search = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      search[i] = eligible[(start + i) % N_IRQ];
    end
    pick = int'(find_first_set(search)) + start;
    if (pick >= N_IRQ) pick = pick - N_IRQ;
    winner = ID_W'(pick);
  end
`else
  // Fixed priority: the lowest-numbered eligible line wins.
  always_comb begin
    search = '0;
    search[N_IRQ-1:0] = eligible;
    winner = ID_W'(find_first_set(search));
  end
`endif

  // Next-state logic. The id is latched on entry to REQ and then held, so a
  // later higher-priority arrival cannot change what the CPU is looking at.
  // In REQ an ack takes precedence over the line being masked off in the
  // same cycle; a masked-off request is withdrawn but stays pending.
  always_comb begin
    state_nxt = state;
    id_nxt    = irq_id;
    ack_clr   = '0;
    unique case (state)
      IDLE: begin
        if (|eligible) begin
          state_nxt = REQ;
          id_nxt    = winner;
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_nxt       = SERVICE;
          ack_clr[irq_id] = 1'b1;
        end else if (!mask[irq_id]) begin
          state_nxt = IDLE;
        end
      end
      SERVICE: begin
        if (irq_eoi) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, registered outputs, pending and mask. A new edge is ORed in after
  // the ack clear so an edge landing on the ack cycle is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      irq_id     <= '0;
      irq_req    <= 1'b0;
      in_service <= 1'b0;
      pending    <= '0;
      mask       <= '0;
    end else begin
      state      <= state_nxt;
      irq_id     <= id_nxt;
      irq_req    <= (state_nxt == REQ);
      in_service <= (state_nxt == SERVICE);
      pending    <= (pending & ~ack_clr) | rise;
      if (mask_we) mask <= mask_wdata;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl (N_IRQ=4, ID_W=2).
// A per-cycle vector table drives inputs and holds the expected registered
// outputs after each clock edge; hand-written sequences cover reset during
// service and the arbitration order with lines repeatedly re-pending.
module tb_irq_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] irq_in;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       irq_ack;
  logic       irq_eoi;
  logic       irq_req;
  logic [1:0] irq_id;
  logic       in_service;
  logic [3:0] mask;
  logic [3:0] pending;

  int checks;
  int failures;

  typedef struct {
    logic [3:0] irq;
    logic       we;
    logic [3:0] wd;
    logic       ack;
    logic       eoi;
    logic       req;
    logic [1:0] id;
    logic       svc;
    logic [3:0] pend;
    logic [3:0] msk;
  } vec_t;

  vec_t vecs[$];

  // With round-robin, the two-line case starts after the last served id (2),
  // so line 3 beats line 1; with fixed priority line 1 goes first.
`ifdef IRQ_PRIO_ROTATE_EN
  localparam logic [1:0] B_FIRST  = 2'd3;
  localparam logic [1:0] B_SECOND = 2'd1;
  localparam logic [3:0] B_LEFT   = 4'b0010;
  localparam logic [1:0] ORDER [4] = '{2'd0, 2'd1, 2'd0, 2'd1};
`else
  localparam logic [1:0] B_FIRST  = 2'd1;
  localparam logic [1:0] B_SECOND = 2'd3;
  localparam logic [3:0] B_LEFT   = 4'b1000;
  localparam logic [1:0] ORDER [4] = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif

  irq_ctrl #(.N_IRQ(4), .ID_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .irq_ack    (irq_ack),
    .irq_eoi    (irq_eoi),
    .irq_req    (irq_req),
    .irq_id     (irq_id),
    .in_service (in_service),
    .mask       (mask),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic add(input logic [3:0] irq, input logic we, input logic [3:0] wd,
                     input logic ack, input logic eoi, input logic req,
                     input logic [1:0] id, input logic svc, input logic [3:0] pend,
                     input logic [3:0] msk);
    vec_t v;
    v.irq = irq; v.we = we; v.wd = wd; v.ack = ack; v.eoi = eoi;
    v.req = req; v.id = id; v.svc = svc; v.pend = pend; v.msk = msk;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic req, input logic [1:0] id,
                             input logic svc, input logic [3:0] pend, input logic [3:0] msk);
    checks++;
    if ({irq_req, irq_id, in_service, pending, mask} !== {req, id, svc, pend, msk}) begin
      failures++;
      $display("[TB] FAIL %s: got req=%b id=%0d svc=%b pend=%b mask=%b, expected req=%b id=%0d svc=%b pend=%b mask=%b",
               name, irq_req, irq_id, in_service, pending, mask, req, id, svc, pend, msk);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    irq_in     = v.irq;
    mask_we    = v.we;
    mask_wdata = v.wd;
    irq_ack    = v.ack;
    irq_eoi    = v.eoi;
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    irq_in = '0; mask_we = 0; mask_wdata = '0; irq_ack = 0; irq_eoi = 0;
  endtask

  task automatic waitReq(input string name, output logic seen);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (irq_req) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: irq_req=0 after 20 cycles, expected 1", name);
    end
  endtask

  initial begin
    logic seen;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idleInputs();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 0, 0, 0, 4'b0000, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    // Single line 2 held high for 5 cycles
    add(4'b0000,1,4'b1111,0,0, 0,0,0,4'b0000,4'b1111);
    add(4'b0100,0,4'b0000,0,0, 0,0,0,4'b0000,4'b1111);
    add(4'b0100,0,4'b0000,0,0, 0,0,0,4'b0000,4'b1111);
    add(4'b0100,0,4'b0000,0,0, 0,0,0,4'b0100,4'b1111);
    add(4'b0100,0,4'b0000,0,0, 1,2,0,4'b0100,4'b1111);
    add(4'b0100,0,4'b0000,1,0, 0,2,1,4'b0000,4'b1111);
    add(4'b0000,0,4'b0000,0,0, 0,2,1,4'b0000,4'b1111);
    add(4'b0000,0,4'b0000,0,1, 0,2,0,4'b0000,4'b1111);
    add(4'b0000,0,4'b0000,0,0, 0,2,0,4'b0000,4'b1111);
    add(4'b0000,0,4'b0000,0,0, 0,2,0,4'b0000,4'b1111);
    // Lines 1 and 3 rise together
    add(4'b1010,0,4'b0000,0,0, 0,2,0,4'b0000,4'b1111);
    add(4'b1010,0,4'b0000,0,0, 0,2,0,4'b0000,4'b1111);
    add(4'b1010,0,4'b0000,0,0, 0,2,0,4'b1010,4'b1111);
    add(4'b1010,0,4'b0000,0,0, 1,B_FIRST,0,4'b1010,4'b1111);
    add(4'b0000,0,4'b0000,1,0, 0,B_FIRST,1,B_LEFT,4'b1111);
    add(4'b0000,0,4'b0000,0,1, 0,B_FIRST,0,B_LEFT,4'b1111);
    add(4'b0000,0,4'b0000,0,0, 1,B_SECOND,0,B_LEFT,4'b1111);
    add(4'b0000,0,4'b0000,1,0, 0,B_SECOND,1,4'b0000,4'b1111);
    add(4'b0000,0,4'b0000,0,1, 0,B_SECOND,0,4'b0000,4'b1111);
    add(4'b0000,0,4'b0000,0,0, 0,B_SECOND,0,4'b0000,4'b1111);
    // Masked edge on line 0 is remembered, then enabled
    add(4'b0000,1,4'b0000,0,0, 0,B_SECOND,0,4'b0000,4'b0000);
    add(4'b0001,0,4'b0000,0,0, 0,B_SECOND,0,4'b0000,4'b0000);
    add(4'b0001,0,4'b0000,0,0, 0,B_SECOND,0,4'b0000,4'b0000);
    add(4'b0001,0,4'b0000,0,0, 0,B_SECOND,0,4'b0001,4'b0000);
    add(4'b0001,0,4'b0000,0,0, 0,B_SECOND,0,4'b0001,4'b0000);
    add(4'b0001,1,4'b0001,0,0, 0,B_SECOND,0,4'b0001,4'b0001);
    add(4'b0001,0,4'b0000,0,0, 1,0,0,4'b0001,4'b0001);
    // New edge on line 0 while line 0 is in service
    add(4'b0000,0,4'b0000,1,0, 0,0,1,4'b0000,4'b0001);
    add(4'b0000,0,4'b0000,0,0, 0,0,1,4'b0000,4'b0001);
    add(4'b0001,0,4'b0000,0,0, 0,0,1,4'b0000,4'b0001);
    add(4'b0001,0,4'b0000,0,0, 0,0,1,4'b0000,4'b0001);
    add(4'b0001,0,4'b0000,0,0, 0,0,1,4'b0001,4'b0001);
    add(4'b0001,0,4'b0000,0,0, 0,0,1,4'b0001,4'b0001);
    add(4'b0001,0,4'b0000,0,1, 0,0,0,4'b0001,4'b0001);
    add(4'b0001,0,4'b0000,0,0, 1,0,0,4'b0001,4'b0001);
    add(4'b0001,0,4'b0000,1,0, 0,0,1,4'b0000,4'b0001);
    add(4'b0001,0,4'b0000,0,1, 0,0,0,4'b0000,4'b0001);
    // Masking line 2 while it is requested withdraws the request
    add(4'b0100,1,4'b1111,0,0, 0,0,0,4'b0000,4'b1111);
    add(4'b0100,0,4'b0000,0,0, 0,0,0,4'b0000,4'b1111);
    add(4'b0100,0,4'b0000,0,0, 0,0,0,4'b0100,4'b1111);
    add(4'b0100,0,4'b0000,0,0, 1,2,0,4'b0100,4'b1111);
    add(4'b0100,1,4'b1011,0,0, 1,2,0,4'b0100,4'b1011);
    add(4'b0100,0,4'b0000,0,0, 0,2,0,4'b0100,4'b1011);
    add(4'b0100,0,4'b0000,0,0, 0,2,0,4'b0100,4'b1011);
    add(4'b0100,1,4'b1111,0,0, 0,2,0,4'b0100,4'b1111);
    add(4'b0100,0,4'b0000,0,0, 1,2,0,4'b0100,4'b1111);
    add(4'b0100,0,4'b0000,1,0, 0,2,1,4'b0000,4'b1111);
    add(4'b0100,0,4'b0000,0,1, 0,2,0,4'b0000,4'b1111);
    // ack and eoi are ignored in IDLE
    add(4'b0000,0,4'b0000,1,1, 0,2,0,4'b0000,4'b1111);
    // ack and a masking write in the same cycle: ack wins
    add(4'b0010,0,4'b0000,0,0, 0,2,0,4'b0000,4'b1111);
    add(4'b0010,0,4'b0000,0,0, 0,2,0,4'b0000,4'b1111);
    add(4'b0010,0,4'b0000,0,0, 0,2,0,4'b0010,4'b1111);
    add(4'b0010,0,4'b0000,0,0, 1,1,0,4'b0010,4'b1111);
    add(4'b0010,1,4'b1101,1,0, 0,1,1,4'b0000,4'b1101);
    add(4'b0000,0,4'b0000,0,1, 0,1,0,4'b0000,4'b1101);
    add(4'b0000,1,4'b1111,0,0, 0,1,0,4'b0000,4'b1111);
    // Second edge on line 3 lands on its ack cycle: pending stays set
    add(4'b1000,0,4'b0000,0,0, 0,1,0,4'b0000,4'b1111);
    add(4'b0000,0,4'b0000,0,0, 0,1,0,4'b0000,4'b1111);
    add(4'b1000,0,4'b0000,0,0, 0,1,0,4'b1000,4'b1111);
    add(4'b1000,0,4'b0000,0,0, 1,3,0,4'b1000,4'b1111);
    add(4'b1000,0,4'b0000,1,0, 0,3,1,4'b1000,4'b1111);
    add(4'b1000,0,4'b0000,0,1, 0,3,0,4'b1000,4'b1111);
    add(4'b1000,0,4'b0000,0,0, 1,3,0,4'b1000,4'b1111);
    add(4'b1000,0,4'b0000,1,0, 0,3,1,4'b0000,4'b1111);
    add(4'b0000,0,4'b0000,0,1, 0,3,0,4'b0000,4'b1111);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].req, vecs[i].id, vecs[i].svc,
                  vecs[i].pend, vecs[i].msk);
    end

    // Reset asserted mid-cycle while line 0 is in service
    @(negedge clk);
    idleInputs();
    irq_in = 4'b0001;
    waitReq("rst_seq_req", seen);
    @(negedge clk);
    irq_ack = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_seq_service", 0, 0, 1, 4'b0000, 4'b1111);
    @(negedge clk);
    irq_ack = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_service", 0, 0, 0, 4'b0000, 4'b0000);
    irq_in = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("rst_after_release", 0, 0, 0, 4'b0000, 4'b0000);

    // Lines 0 and 1 re-pend after every ack; check the served order
    @(negedge clk);
    mask_we = 1'b1; mask_wdata = 4'b1111; irq_in = 4'b0011;
    @(negedge clk);
    mask_we = 1'b0; irq_in = 4'b0000;
    for (int r = 0; r < 4; r++) begin
      logic [1:0] served;
      waitReq($sformatf("order%0d_req", r), seen);
      checks++;
      if (irq_id !== ORDER[r]) begin
        failures++;
        $display("[TB] FAIL order%0d_id: got id=%0d, expected id=%0d", r, irq_id, ORDER[r]);
      end
      served = irq_id;
      @(negedge clk);
      irq_ack = 1'b1;
      @(negedge clk);
      irq_ack = 1'b0;
      irq_in  = 4'b0001 << served;
      @(negedge clk);
      irq_in  = 4'b0000;
      repeat (3) @(negedge clk);
      irq_eoi = 1'b1;
      @(negedge clk);
      irq_eoi = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller for the Hunter_RV32 core.
- Synchronises N external interrupt lines and rising-edge detects each one.
- Latches detected edges as pending, applies a software-writable enable mask, and arbitrates among enabled pending lines.
- Presents one interrupt at a time to the CPU trap logic through a req/ack handshake, then holds it in service until end-of-interrupt (EOI).

Parameters:
- N_IRQ, 4, number of interrupt lines (2..16)
- ID_W, 2, width of interrupt id; must be ≥ clog2(N_IRQ)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- irq_in  in  N_IRQ  raw asynchronous interrupt lines
- mask_we  in  1  mask write strobe
- mask_wdata  in  N_IRQ  new enable mask; 1 = enabled
- irq_ack  in  1  CPU accepts the presented interrupt
- irq_eoi  in  1  CPU finished its handler (one-cycle pulse)
- irq_req  out  1  interrupt request to CPU
- irq_id  out  ID_W  id of the requested or in-service interrupt
- in_service  out  1  a handler is active
- mask  out  N_IRQ  current enable mask
- pending  out  N_IRQ  current pending bits

Behaviour:
- Reset (async on rst=1): all sync flops 0; pending=0; mask=0 (all disabled); state IDLE; irq_req=0; irq_id=0; in_service=0.
- Per line, input path:
  - 2-flop synchroniser, then a delay flop.
  - edge = s2 & ~s2_d.
  - A level held high produces exactly one edge.
- Latency: irq_in first sampled high at clock edge k → pending set at edge k+2 → irq_req high after edge k+3 (when enabled and state IDLE).
- Pending bit i:
  - Set on edge_i regardless of mask (a masked edge is remembered).
  - Cleared only when it is acknowledged.
  - Same-cycle edge_i and ack-clear of i: set wins, bit stays 1.
- Mask:
  - On mask_we, mask ← mask_wdata at the clock edge.
  - eligible = pending & mask.
- Arbitration: fixed priority, lowest index wins.
- FSM, 2-bit encoding:
  - IDLE: if eligible≠0 → REQ; latch irq_id = winner; irq_req ← 1.
  - REQ:
    - irq_req=1 and irq_id held stable; a higher-priority arrival does not change irq_id.
    - On irq_ack: clear pending[irq_id]; irq_req ← 0; in_service ← 1; → SERVICE.
    - Else if mask[irq_id] becomes 0 (after a write): irq_req ← 0; → IDLE; the pending bit is retained.
    - irq_ack and the masking write in the same cycle: ack wins.
  - SERVICE:
    - irq_id holds the served id; no new request (no nesting).
    - On irq_eoi: in_service ← 0; → IDLE.
    - Earliest next irq_req is one cycle after the IDLE re-entry edge.
- Ignored inputs: irq_ack outside REQ; irq_eoi outside SERVICE.
- Outputs are registered; no combinational path from inputs to irq_req.
- Reset mid-handshake: everything returns to its reset values immediately; the CPU must treat a dropped irq_req as withdrawn.

Optional Feature:
- Macro IRQ_PRIO_ROTATE_EN.
- Defined: round-robin arbitration.
  - The search starts at (last_served+1) mod N_IRQ.
  - last_served updates on ack and resets to N_IRQ-1, so after reset index 0 has top priority.
- Undefined: fixed priority, lowest index wins; no last_served register.

Decomposition:
- Package irq_pkg:
  - FSM state localparams (IDLE=2'b00, REQ=2'b01, SERVICE=2'b10).
  - Default N_IRQ.
  - A find-first-set function used by the arbiter.
- Sub-module irq_sync_edge: 2-flop synchroniser plus rising-edge pulse, one instance per line via generate.

Test Plan:
- Reset, then mask=4'b1111, pulse irq_in[2] high for 5 cycles → after 3 cycles irq_req=1, irq_id=2; ack → pending[2]=0, in_service=1; eoi → IDLE; no second request.
- irq_in[1] and irq_in[3] rise in the same cycle → irq_id=1 first; after ack+eoi, irq_id=3 one cycle after IDLE.
- mask=0, edge on line 0 → pending=4'b0001, irq_req stays 0; write mask=4'b0001 → irq_req=1, irq_id=0 after 2 cycles.
- In REQ for id 2, write mask=4'b1011 → irq_req drops, state IDLE, pending[2] stays 1; re-enable → request reappears.
- During SERVICE of id 0, new edge on line 0 → pending[0]=1, no irq_req until eoi, then re-request of id 0.
- Assert rst while in SERVICE → irq_req=0, in_service=0, pending=0, mask=0 immediately.
- With IRQ_PRIO_ROTATE_EN, lines 0 and 1 continuously re-pending → served order 0,1,0,1.
